pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the MIPS core. It generalises the fixed EX/MEM latch and serves as IF/ID, ID/EX, EX/MEM or MEM/WB.
- Configurable payload and control widths.
- Stall (hold) and flush (bubble insert) controls.
- Per-entry valid bit.
- $zero write suppression.
- Saturating stall/flush event counters for the performance monitor.

Parameters:
DATA_W, 32, width of datapath payload (ALU result, store data, PC, etc. concatenated by the instantiating stage)
CTRL_W, 4, width of control bundle (RegWrite, MemToReg, MEM_WEN, MEM_REN, ...)
REG_W, 5, register specifier width (RS, RT, RD)
RW_BIT, 0, index within ctrl of the RegWrite bit, used for $zero suppression
ZERO_SUPPRESS, 1, 1 = clear RegWrite when the incoming RD is 0; 0 = pass through unchanged
CNT_W, 16, width of each event counter

Ports:
clock  in  1  stage clock, all state updates on the rising edge
reset  in  1  synchronous active-high reset
stall  in  1  hold current contents
flush  in  1  replace contents with a bubble
cnt_clr  in  1  synchronous clear of both event counters
in_valid  in  1  incoming entry is a real instruction
in_data  in  DATA_W  incoming payload
in_ctrl  in  CTRL_W  incoming control bundle
in_rs  in  REG_W  incoming source register 1
in_rt  in  REG_W  incoming source register 2
in_rd  in  REG_W  incoming destination register
out_valid  out  1  registered valid
out_data  out  DATA_W  registered payload
out_ctrl  out  CTRL_W  registered control
out_rs  out  REG_W  registered RS
out_rt  out  REG_W  registered RT
out_rd  out  REG_W  registered RD
stall_cnt  out  CNT_W  cycles spent stalled
flush_cnt  out  CNT_W  flush events

Behaviour:
- All state is registered; latency is exactly 1 cycle from in_* to out_*. No combinational path from inputs to outputs.
- Reset (sampled on the clock edge):
  - out_valid, out_data, out_ctrl, out_rs, out_rt, out_rd, stall_cnt and flush_cnt all become 0.
  - Every output, including the control fields, has a defined reset value. Reset overrides all other inputs.
- Update priority each edge: reset > flush > stall > load.
- Flush: out_valid=0, and out_ctrl, out_rd, out_rs, out_rt, out_data all become 0. The bubble therefore cannot write the register file or memory and cannot match any forwarding compare.
- Stall (flush=0): every out_* field holds its value.
- Load (flush=0, stall=0):
  - in_valid=1: capture all in_* fields, out_valid=1.
  - in_valid=0: load a bubble, identical to the flush result. in_ctrl and in_rd are ignored.
- $zero suppression: when ZERO_SUPPRESS=1 and a valid load has in_rd==0, the captured out_ctrl[RW_BIT] is forced to 0. All other ctrl bits pass unchanged. When ZERO_SUPPRESS=0 this logic is absent.
- Simultaneous stall and flush: flush wins, and the stage becomes a bubble.
- stall_cnt:
  - Increments on each edge with stall=1, flush=0 and reset=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
- flush_cnt:
  - Increments on each edge with flush=1 and reset=0, whether or not the stage held a valid entry.
  - Saturates at 2^CNT_W-1.
- cnt_clr: both counters become 0 on that edge and the current-cycle event is not counted. Pipeline contents are unaffected.
- Reset mid-stall or mid-flush: reset takes effect; the counters go to 0, not to the incremented value.
- Parameter legality: RW_BIT < CTRL_W and CNT_W >= 1. Violations are a compile-time error (generate-time check).

Test Plan:
1. Reset then load: assert reset 1 cycle; all outputs read 0. Then drive in_valid=1, data=0xDEADBEEF, ctrl=4'b1011, rs=3, rt=4, rd=7 -> next edge out_data=0xDEADBEEF, ctrl=4'b1011, rd=7, valid=1.
2. Stall hold: entry A loaded, stall=1 for 3 cycles while the inputs change to B -> outputs stay at A and stall_cnt=3. Releasing stall -> B appears 1 cycle later.
3. Flush priority: stall=1 and flush=1 on the same edge with a valid entry held -> out_valid=0, ctrl=0, rd=0, data=0; flush_cnt=1; stall_cnt unchanged.
4. $zero suppression: valid load with rd=0, ctrl=4'b1111, RW_BIT=0 -> out_ctrl=4'b1110. Same load with rd=5 -> 4'b1111. Repeat with ZERO_SUPPRESS=0 and rd=0 -> 4'b1111.
5. Counter saturation and clear: CNT_W=3, hold stall for 10 cycles -> stall_cnt=7 and stays at 7. Pulse cnt_clr with stall=1 -> stall_cnt=0 on that edge, then 1 on the next.
6. Reset mid-operation: valid entry loaded with stall=1, stall_cnt=5; assert reset with stall and flush both high -> next edge all outputs and both counters are 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid, stall/flush and perf counters.
// Latency 1 cycle; stall holds the entry, flush or an invalid load inserts an all-zero bubble.
module pipe_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 4,
  parameter int REG_W         = 5,
  parameter int RW_BIT        = 0,
  parameter int ZERO_SUPPRESS = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  generate
    if (RW_BIT < 0 || RW_BIT >= CTRL_W || CNT_W < 1) begin : g_param_err
      $error("pipe_stage_reg: illegal parameters (need 0 <= RW_BIT < CTRL_W and CNT_W >= 1)");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0] ctrl_cap;
  logic              take_bubble;

  // A write to $zero must never reach the register file, so drop RegWrite at capture time.
  generate
    if (ZERO_SUPPRESS != 0) begin : g_zero_sup
      always_comb begin
        ctrl_cap = in_ctrl;
        if (in_rd == '0) ctrl_cap[RW_BIT] = 1'b0;
      end
    end else begin : g_no_zero_sup
      assign ctrl_cap = in_ctrl;
    end
  endgenerate

  assign take_bubble = flush || (!stall && !in_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (take_bubble) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_ctrl  <= '0;
        out_rs    <= '0;
        out_rt    <= '0;
        out_rd    <= '0;
      end else if (!stall) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_ctrl  <= ctrl_cap;
        out_rs    <= in_rs;
        out_rt    <= in_rt;
        out_rd    <= in_rd;
      end

      // Flush outranks stall, so a cycle with both counts only as a flush.
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
        if (stall && !flush && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
